// File: rtl/seg_load_arbiter.sv
// Two-requester round-robin arbiter that sequences segment-register loads as
// IDLE -> LOAD -> ACK and opens an interrupt-inhibit window after each SS load.
module seg_load_arbiter #(
  parameter int WIDTH          = 20,
  parameter int NSEG           = 4,
  parameter int SELW           = 2,
  parameter int SS_INDEX       = 2,
  parameter int INHIBIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [SELW-1:0]  sel_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [SELW-1:0]  sel_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic [NSEG-1:0]  seg_load,
  output logic [WIDTH-1:0] seg_data,
  output logic             err,
  output logic             busy,
  output logic             int_inhibit
);

  localparam int              CW       = (INHIBIT_CYCLES < 1) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam logic [CW-1:0]   INH_LOAD = CW'(INHIBIT_CYCLES);
  localparam logic [SELW:0]   NSEG_W   = (SELW+1)'(NSEG);
  localparam logic [SELW-1:0] SS_SEL   = SELW'(SS_INDEX);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_e;

  state_e           state_q;
  logic             ptr_b_q;
  logic             win_b_q;
  logic [SELW-1:0]  sel_q;
  logic [NSEG-1:0]  seg_load_q;
  logic [WIDTH-1:0] seg_data_q;
  logic             ack_a_q, ack_b_q, err_q, busy_q, inh_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             grant_b;
  logic [SELW-1:0]  win_sel;
  logic [WIDTH-1:0] win_data;
  logic [NSEG-1:0]  load_dec;
  logic             sel_oob;
  logic             ss_load;

  always_comb begin
    // B wins when alone, or when both request and the pointer favours B
    grant_b  = req_b & (~req_a | ptr_b_q);
    win_sel  = grant_b ? sel_b  : sel_a;
    win_data = grant_b ? data_b : data_a;
    load_dec = '0;
    for (int i = 0; i < NSEG; i++) load_dec[i] = (win_sel == SELW'(i));
    sel_oob  = ({1'b0, sel_q} >= NSEG_W);
    ss_load  = (state_q == LOAD) && (sel_q == SS_SEL);
    cnt_d    = cnt_q;
    if (ss_load)             cnt_d = INH_LOAD;
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_b_q    <= 1'b0;
      win_b_q    <= 1'b0;
      sel_q      <= '0;
      seg_load_q <= '0;
      seg_data_q <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_a | req_b) begin
          state_q    <= LOAD;
          win_b_q    <= grant_b;
          ptr_b_q    <= ~grant_b;
          sel_q      <= win_sel;
          seg_load_q <= load_dec;
          seg_data_q <= win_data;
          busy_q     <= 1'b1;
        end
        LOAD: begin
          state_q    <= ACK;
          seg_load_q <= '0;
          ack_a_q    <= ~win_b_q;
          ack_b_q    <= win_b_q;
          err_q      <= sel_oob;
        end
        ACK: begin
          state_q <= IDLE;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window counter; the flag is registered off the next count so it rises in the ACK cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      inh_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      inh_q <= (cnt_d != '0);
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign seg_load    = seg_load_q;
  assign seg_data    = seg_data_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign int_inhibit = inh_q;

endmodule

// File: tb/tb_seg_load_arbiter.sv
// Bench for seg_load_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level model (NSEG=4 and NSEG=3 instances).
module tb_seg_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [1:0]  sel_a, sel_b;
  logic [19:0] data_a, data_b;

  logic        ack_a, ack_b, err, busy, int_inhibit;
  logic [3:0]  seg_load;
  logic [19:0] seg_data;
  logic        ack_a3, ack_b3, err3, busy3, inh3;
  logic [2:0]  seg_load3;
  logic [19:0] seg_data3;

  always #5 clk = ~clk;

  seg_load_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .sel_a(sel_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .sel_b(sel_b), .data_b(data_b), .ack_b(ack_b),
    .seg_load(seg_load), .seg_data(seg_data), .err(err), .busy(busy),
    .int_inhibit(int_inhibit)
  );

  seg_load_arbiter #(.NSEG(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .sel_a(sel_a), .data_a(data_a), .ack_a(ack_a3),
    .req_b(req_b), .sel_b(sel_b), .data_b(data_b), .ack_b(ack_b3),
    .seg_load(seg_load3), .seg_data(seg_data3), .err(err3), .busy(busy3),
    .int_inhibit(inh3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: a grant at edge g owns the bus for edges g..g+2;
  // the SS window covers the INH edges starting one after the grant.
  localparam int INH = 2;
  int          edge_n, t_start, ss_edge, prev_ss;
  logic        tx_b, prio_b;
  logic [1:0]  tx_sel;
  logic [19:0] last_data;

  task automatic model_reset();
    edge_n = 0; t_start = -100; ss_edge = -100; prev_ss = -100;
    tx_b = 1'b0; prio_b = 1'b0; tx_sel = 2'd0; last_data = '0;
  endtask

  task automatic model_step();
    edge_n++;
    if (edge_n >= t_start + 3 && (req_a || req_b)) begin
      tx_b      = req_b && (!req_a || prio_b);
      prio_b    = !tx_b;
      tx_sel    = tx_b ? sel_b : sel_a;
      last_data = tx_b ? data_b : data_a;
      t_start   = edge_n;
      if (tx_sel == 2'd2) begin prev_ss = ss_edge; ss_edge = edge_n + 1; end
    end
  endtask

  always @(posedge clk) if (reset) model_step();

  function automatic logic [31:0] exp_vec(input int nseg);
    logic       in_load, in_ack, inh;
    logic [3:0] ld;
    in_load = (edge_n == t_start);
    in_ack  = (edge_n == t_start + 1);
    inh     = (edge_n >= ss_edge && edge_n < ss_edge + INH) ||
              (edge_n >= prev_ss && edge_n < prev_ss + INH);
    ld      = (in_load && int'(tx_sel) < nseg) ? 4'(1 << tx_sel) : 4'b0;
    return {3'b0, in_ack & ~tx_b, in_ack & tx_b, ld, last_data,
            in_ack && int'(tx_sel) >= nseg, in_load | in_ack, inh};
  endfunction

  task automatic model_check();
    check("rnd_n4", {3'b0, ack_a, ack_b, seg_load, seg_data, err, busy, int_inhibit}, exp_vec(4));
    check("rnd_n3", {3'b0, ack_a3, ack_b3, 1'b0, seg_load3, seg_data3, err3, busy3, inh3}, exp_vec(3));
  endtask

  task automatic check_idle(input string nm);
    check(nm,        {ack_a, ack_b, seg_load, seg_data, err, busy, int_inhibit}, 32'd0);
    check({nm, "3"}, {ack_a3, ack_b3, seg_load3, seg_data3, err3, busy3, inh3}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
  endtask

  typedef struct {
    logic ra; logic [1:0] sa; logic [19:0] da;
    logic rb; logic [1:0] sb; logic [19:0] db;
    logic [3:0] e_load; logic [19:0] e_data; logic e_b; logic e_err3; logic e_inh;
  } vec_t;

  vec_t       tv[7];
  logic [3:0] rr_load[9];
  logic       rr_acka[9], rr_ackb[9], inh_exp[7];

  initial begin
    tv[0] = '{1'b1, 2'd1, 20'hAD1,  1'b0, 2'd0, 20'h0,     4'b0010, 20'hAD1,  1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 2'd0, 20'h0,    1'b1, 2'd0, 20'h12345, 4'b0001, 20'h12345, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 2'd0, 20'h0AAAA, 1'b1, 2'd3, 20'h0BBBB, 4'b0001, 20'h0AAAA, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 2'd3, 20'hF0F0F, 1'b0, 2'd0, 20'h0,     4'b1000, 20'hF0F0F, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 2'd0, 20'h0,    1'b1, 2'd2, 20'h5A5A5, 4'b0100, 20'h5A5A5, 1'b1, 1'b0, 1'b1};
    tv[5] = '{1'b1, 2'd2, 20'h00002, 1'b1, 2'd1, 20'hFFFFF, 4'b0100, 20'h00002, 1'b0, 1'b0, 1'b1};
    tv[6] = '{1'b0, 2'd0, 20'h0,    1'b1, 2'd3, 20'h33333, 4'b1000, 20'h33333, 1'b1, 1'b1, 1'b0};
    rr_load = '{4'b0001, 4'b0, 4'b0, 4'b1000, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0};
    rr_acka = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rr_ackb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    inh_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    sel_a = '0; sel_b = '0; data_a = '0; data_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("por_state");
    reset = 1'b1;

    // Directed single transactions, each from a fresh reset (pointer = A)
    for (int k = 0; k < 7; k++) begin
      do_reset();
      req_a = tv[k].ra; sel_a = tv[k].sa; data_a = tv[k].da;
      req_b = tv[k].rb; sel_b = tv[k].sb; data_b = tv[k].db;
      @(negedge clk);
      check($sformatf("tv%0d_load", k), {seg_load, seg_data, busy, ack_a, ack_b},
            {tv[k].e_load, tv[k].e_data, 1'b1, 2'b00});
      check($sformatf("tv%0d_load3", k), {seg_load3, busy3}, {tv[k].e_load[2:0], 1'b1});
      @(negedge clk);
      check($sformatf("tv%0d_ack", k),
            {ack_a, ack_b, seg_load, err, err3, int_inhibit, inh3, seg_data},
            {~tv[k].e_b, tv[k].e_b, 4'b0, 1'b0, tv[k].e_err3, tv[k].e_inh, tv[k].e_inh, tv[k].e_data});
      req_a = 1'b0; req_b = 1'b0;
    end

    // Both requesters held: A, B, A grants three cycles apart
    do_reset();
    req_a = 1'b1; sel_a = 2'd0; data_a = 20'h11111;
    req_b = 1'b1; sel_b = 2'd3; data_b = 20'h22222;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d", k), {seg_load, ack_a, ack_b}, {rr_load[k], rr_acka[k], rr_ackb[k]});
    end
    req_a = 1'b0; req_b = 1'b0;

    // Repeated SS loads: window is two cycles from each ACK
    do_reset();
    req_b = 1'b1; sel_b = 2'd2; data_b = 20'h77777;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("inh%0d", k), {int_inhibit, inh3}, {inh_exp[k], inh_exp[k]});
      if (k == 5) req_b = 1'b0;
    end

    // Request dropped during LOAD still completes, then stays idle
    do_reset();
    req_a = 1'b1; sel_a = 2'd1; data_a = 20'hABCDE;
    @(negedge clk);
    check("drop_load", {seg_load, seg_data}, {4'b0010, 20'hABCDE});
    req_a = 1'b0;
    @(negedge clk);
    check("drop_ack", {ack_a, ack_b, busy}, 3'b101);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drop_idle", {ack_a, ack_b, busy, seg_load}, 7'b0);
    end

    // Async reset in the middle of a LOAD cycle
    do_reset();
    req_a = 1'b1; sel_a = 2'd1; data_a = 20'h0F00D;
    @(posedge clk); #2;
    check("pre_rst_load", {seg_load, busy}, {4'b0010, 1'b1});
    reset = 1'b0; req_a = 1'b0; model_reset();
    #1 check_idle("mid_load_rst");
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_ack", {ack_a, ack_b, busy, seg_load}, 7'b0);
    end

    // Async reset inside the inhibit window
    req_b = 1'b1; sel_b = 2'd2; data_b = 20'h55555;
    @(negedge clk); @(negedge clk);
    check("win_open", {int_inhibit, ack_b}, 2'b11);
    req_b = 1'b0;
    #1 reset = 1'b0; model_reset();
    #1 check("win_rst", {int_inhibit, inh3, ack_b}, 3'b000);
    @(negedge clk); reset = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      model_check();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; model_reset();
      end
      req_a  = ($urandom_range(0, 2) != 0);
      req_b  = ($urandom_range(0, 2) != 0);
      sel_a  = 2'($urandom_range(0, 3));
      sel_b  = 2'($urandom_range(0, 3));
      data_a = 20'($urandom);
      data_b = 20'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
